// File: rtl/phase_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phase_accum_pkg
//  Purpose  : Shared DDS definitions: default phase width and the
//             frequency-word shadow state encoding. Waveform shapers that
//             consume the phase import the same width constant.
//  Revision : 1.0  initial release
// ============================================================================
package phase_accum_pkg;

    // Default phase / tuning word width in bits
    localparam int C_PHASE_W = 14;

    // Frequency-word shadow control states
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,  // no word pending, handshake open
        ST_PENDING = 1'b1   // word held in shadow, waiting for a safe load point
    } fw_state_e;

endpackage : phase_accum_pkg
`default_nettype wire

// File: rtl/phase_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : phase_accum_if
//  Purpose  : Control, frequency-word handshake and phase output bundle of
//             the phase accumulator. The master drives control and the
//             offered word; the slave (the accumulator) returns phase state.
//  Revision : 1.0  initial release
// ============================================================================
interface phase_accum_if
    import phase_accum_pkg::*;
#(
    parameter int N = C_PHASE_W
);
    logic         ena;
    logic         fw_valid;
    logic [N-1:0] fw_data;
    logic         fw_ready;
    logic         phase_clr;
    logic [N-1:0] phase;
    logic         wrap;
    logic [N-1:0] fw_active;

    modport master (
        output ena, fw_valid, fw_data, phase_clr,
        input  fw_ready, phase, wrap, fw_active
    );

    modport slave (
        input  ena, fw_valid, fw_data, phase_clr,
        output fw_ready, phase, wrap, fw_active
    );
endinterface : phase_accum_if
`default_nettype wire

// File: rtl/phase_fw_shadow.sv
`default_nettype none
// ============================================================================
//  Module   : phase_fw_shadow
//  Purpose  : Frequency-word shadow register with IDLE/PENDING control.
//             Accepts one word, holds it, and strobes load_o at the point
//             where swapping it into the active increment keeps the phase
//             continuous (carry-out, zero increment, or phase clear).
//  Revision : 1.0  initial release
// ============================================================================
module phase_fw_shadow
    import phase_accum_pkg::*;
#(
    parameter int N = C_PHASE_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         fw_valid_i,
    input  wire logic [N-1:0] fw_data_i,
    input  wire logic         ena_i,
    input  wire logic         carry_i,        // raw carry of phase + fw_active
    input  wire logic         phase_clr_i,
    input  wire logic         active_zero_i,  // fw_active == 0, carry impossible
    output logic              fw_ready_o,
    output logic              load_o,
    output logic [N-1:0]      shadow_o
);

    fw_state_e    state_q, state_d;
    logic [N-1:0] shadow_q, shadow_d;

    // State and shadow registers; reset discards any word offered on that edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state, capture and load-strobe decode
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        fw_ready_o = 1'b0;
        load_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fw_ready_o = 1'b1;
                if (fw_valid_i) begin
                    shadow_d = fw_data_i;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // New offers are ignored here; the held word is loaded on a
                // wrap, immediately if no wrap can ever come, or on a clear.
                if ((ena_i && carry_i) || active_zero_i || phase_clr_i) begin
                    load_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign shadow_o = shadow_q;

endmodule : phase_fw_shadow
`default_nettype wire

// File: rtl/phase_accum.sv
`default_nettype none
// ============================================================================
//  Module   : phase_accum
//  Purpose  : DDS phase accumulator. Adds the active frequency word to the
//             phase every enabled cycle, flags carry-out as a one-cycle wrap
//             pulse, and swaps in new frequency words phase-continuously.
//  Revision : 1.0  initial release
// ============================================================================
module phase_accum
    import phase_accum_pkg::*;
#(
    parameter int N = C_PHASE_W
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    phase_accum_if.slave bus
);

    logic [N-1:0] phase_q;
    logic         wrap_q;
    logic [N-1:0] fw_active_q;
    logic [N:0]   sum_w;
    logic         carry_w;
    logic         load_w;
    logic [N-1:0] shadow_w;

    assign sum_w   = {1'b0, phase_q} + {1'b0, fw_active_q};
    assign carry_w = sum_w[N];

    phase_fw_shadow #(
        .N(N)
    ) u_fw_shadow (
        .clk           (clk),
        .rst_n         (rst_n),
        .fw_valid_i    (bus.fw_valid),
        .fw_data_i     (bus.fw_data),
        .ena_i         (bus.ena),
        .carry_i       (carry_w),
        .phase_clr_i   (bus.phase_clr),
        .active_zero_i (fw_active_q == '0),
        .fw_ready_o    (bus.fw_ready),
        .load_o        (load_w),
        .shadow_o      (shadow_w)
    );

    // Phase/wrap registers: clear beats enable, wrap only on a real carry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.phase_clr) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.ena) begin
            phase_q <= sum_w[N-1:0];
            wrap_q  <= carry_w;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    // Active increment takes the shadow word on the load strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fw_active_q <= '0;
        end else if (load_w) begin
            fw_active_q <= shadow_w;
        end
    end

    assign bus.phase     = phase_q;
    assign bus.wrap      = wrap_q;
    assign bus.fw_active = fw_active_q;

endmodule : phase_accum
`default_nettype wire

// File: tb/tb_phase_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_accum
//  Purpose  : Directed, table-driven self-checking bench for phase_accum
//             (N = 14), plus a short hand-written wrap sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_accum;

    localparam int N = 14;

    typedef struct {
        logic         rst_n;
        logic         ena;
        logic         clr;
        logic         valid;
        logic [N-1:0] data;
        logic [N-1:0] ph;
        logic         wr;
        logic [N-1:0] act;
        logic         rdy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vq[$];

    phase_accum_if #(.N(N)) bus ();

    phase_accum #(
        .N(N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic add(input bit r, input bit e, input bit c, input bit v, input int d,
                       input int p, input bit w, input int a, input bit rd);
        vec_t t;
        t.rst_n = r; t.ena = e; t.clr = c; t.valid = v; t.data = d[N-1:0];
        t.ph = p[N-1:0]; t.wr = w; t.act = a[N-1:0]; t.rdy = rd;
        vq.push_back(t);
    endtask

    task automatic drive(input bit r, input bit e, input bit c, input bit v, input int d);
        rst_n         = r;
        bus.ena       = e;
        bus.phase_clr = c;
        bus.fw_valid  = v;
        bus.fw_data   = d[N-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input int p, input bit w, input int a, input bit rd);
        chk("phase",     idx, int'(bus.phase),     p);
        chk("wrap",      idx, int'(bus.wrap),      int'(w));
        chk("fw_active", idx, int'(bus.fw_active), a);
        chk("fw_ready",  idx, int'(bus.fw_ready),  int'(rd));
    endtask

    initial begin
        int mphase;
        int sum;
        n_checks = 0;
        n_errors = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);

        //   rst en clr vld data   | phase  wr act   rdy
        add(0, 0, 0, 0, 0,          0,     0, 0,    1);  // reset state
        // load 4096 from zero increment, count up through a wrap
        add(1, 1, 0, 1, 4096,       0,     0, 0,    0);
        add(1, 1, 0, 0, 0,          0,     0, 4096, 1);
        add(1, 1, 0, 0, 0,          4096,  0, 4096, 1);
        add(1, 1, 0, 0, 0,          8192,  0, 4096, 1);
        add(1, 1, 0, 0, 0,          12288, 0, 4096, 1);
        add(1, 1, 0, 0, 0,          0,     1, 4096, 1);
        add(1, 1, 0, 0, 0,          4096,  0, 4096, 1);
        // mid-period 2048 accepted; a later offer of 100 is ignored
        add(1, 1, 0, 1, 2048,       8192,  0, 4096, 0);
        add(1, 1, 0, 1, 100,        12288, 0, 4096, 0);
        add(1, 1, 0, 0, 0,          0,     1, 2048, 1);
        add(1, 1, 0, 0, 0,          2048,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          4096,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          6144,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          8192,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          10240, 0, 2048, 1);
        add(1, 1, 0, 0, 0,          12288, 0, 2048, 1);
        add(1, 1, 0, 0, 0,          14336, 0, 2048, 1);
        add(1, 1, 0, 0, 0,          0,     1, 2048, 1);  // 8-cycle period
        add(1, 1, 0, 0, 0,          2048,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          4096,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          6144,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          8192,  0, 2048, 1);
        add(1, 1, 0, 0, 0,          10240, 0, 2048, 1);
        add(1, 1, 0, 1, 1024,       12288, 0, 2048, 0);
        // clear beats enable and flushes the pending word
        add(1, 1, 1, 0, 0,          0,     0, 1024, 1);
        add(1, 1, 0, 0, 0,          1024,  0, 1024, 1);
        // enable low: hold, wrap 0, handshake still accepts
        add(1, 0, 0, 1, 8192,       1024,  0, 1024, 0);
        add(1, 0, 0, 0, 0,          1024,  0, 1024, 0);
        add(1, 0, 0, 0, 0,          1024,  0, 1024, 0);
        // reset while pending; word offered on the reset edge is dropped
        add(0, 1, 0, 1, 555,        0,     0, 0,    1);
        add(1, 1, 0, 0, 0,          0,     0, 0,    1);
        add(1, 1, 0, 0, 0,          0,     0, 0,    1);
        // zero increment: new word loads next edge even with enable low
        add(1, 1, 0, 1, 1,          0,     0, 0,    0);
        add(1, 0, 0, 0, 0,          0,     0, 1,    1);
        add(1, 1, 0, 0, 0,          1,     0, 1,    1);
        add(1, 1, 0, 0, 0,          2,     0, 1,    1);

        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].ena, vq[i].clr, vq[i].valid, int'(vq[i].data));
            tick();
            check_all(i, int'(vq[i].ph), vq[i].wr, int'(vq[i].act), vq[i].rdy);
        end

        // Largest increment: every add after the first carries out
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16383);
        tick();
        check_all(100, 0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick();
        check_all(101, 0, 1'b0, 16383, 1'b1);
        mphase = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
            tick();
            sum    = mphase + 16383;
            mphase = sum % 16384;
            check_all(102 + k, mphase, (sum >= 16384), 16383, 1'b1);
        end
        // Wrap pulse must drop on the first enable-low cycle after a carry
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick();
        check_all(107, mphase, 1'b0, 16383, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_phase_accum
`default_nettype wire

// File: doc/phase_accum.md
PHASE_ACCUM -- requirements
Module: phase_accum

Interface
REQ-001 Parameter: n, default 14, phase and tuning word width in bits; downstream waveform shapers consume this phase.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: ena  input  1  count enable; when low the accumulator holds.
REQ-005 Port: fw_valid  input  1  a new frequency word is offered.
REQ-006 Port: fw_data  input  n  offered frequency word (phase increment per enabled cycle).
REQ-007 Port: fw_ready  output  1  block can accept a frequency word.
REQ-008 Port: phase_clr  input  1  synchronous phase clear request.
REQ-009 Port: phase  output  n  registered accumulator value.
REQ-010 Port: wrap  output  1  one-cycle pulse, registered, on accumulator carry-out.
REQ-011 Port: fw_active  output  n  frequency word currently in use.

Function
REQ-012 Accumulator: on an enabled cycle, phase_next = (phase + fw_active) mod 2^n; wrap = carry out of that n-bit add.
REQ-013 Latency: phase and wrap reflect the add one clock after the enabled edge; no combinational path from inputs to outputs.
REQ-014 Two states: IDLE (no word pending), PENDING (word held in a shadow register).
REQ-015 fw_ready is 1 in IDLE and 0 in PENDING; a transfer occurs on the edge where fw_valid and fw_ready are both 1.
REQ-016 IDLE -> PENDING on transfer; fw_data is captured into the shadow register.
REQ-017 PENDING -> IDLE on the edge where an enabled add produces carry-out; fw_active loads the shadow value on that same edge, so the new increment applies from the first post-wrap add (phase-continuous change).
REQ-018 If fw_active is 0 while PENDING, the shadow value is loaded on the next edge regardless of ena, and the state returns to IDLE (no carry can ever occur).
REQ-019 fw_valid while PENDING is ignored; the shadow value is not overwritten.
REQ-020 phase_clr: next phase = 0 and wrap = 0, taking priority over ena. A pending word is loaded into fw_active on the same edge, returning the state to IDLE.
REQ-021 ena low: phase, wrap (forced 0), and fw_active hold; the handshake still accepts into the shadow register.
REQ-022 wrap is 0 on any cycle without a carry-out, including ena-low and phase_clr cycles.

Reset
REQ-023 With rst_n low at a clock edge: phase = 0, wrap = 0, fw_active = 0, shadow = 0, state = IDLE (fw_ready = 1).
REQ-024 Reset overrides phase_clr, ena, and the handshake; a word transferred on a reset edge is discarded.

Structure
REQ-025 A shared DDS package holds the default phase width (14) and the state enumeration; downstream shapers use the same width constant.
REQ-026 One sub-module is used: phase_fw_shadow (shadow register plus IDLE/PENDING control, outputs fw_ready and the load strobe). The adder and output registers stay in phase_accum.

Verification
REQ-027 n=14, reset, then load fw=4096 with ena=1 -> phase 0,4096,8192,12288,0; wrap=1 exactly on the cycle phase returns to 0.
REQ-028 fw_active=4096 running; transfer fw=2048 mid-period -> fw_ready=0 until wrap; first post-wrap step is +2048; wrap period becomes 8 cycles.
REQ-029 fw_active=0, transfer fw=1 -> fw_active=1 one edge later, phase starts incrementing by 1; fw_ready returns to 1.
REQ-030 PENDING with shadow=2048; drive fw_valid with fw=100 -> not accepted (fw_ready=0); 2048 is applied at the next wrap.
REQ-031 phase=12288, ena=1, phase_clr=1 -> phase=0, wrap=0; ena=0 for 3 cycles -> phase holds and wrap stays 0.
REQ-032 Running with PENDING, assert rst_n=0 for one edge -> all outputs 0, fw_ready=1, and the shadow word is discarded.
